spi_tx_master: RTL and testbench

//  Parametrised SPI master transmitter; successor to the fixed 8-bit output SPI stage.

---
 rtl/spi_tx_master.sv | 113 +++++++++++
 tb/tb_spi_tx_master.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_master.sv
// SPI master transmitter: valid/ready word in, MSB-first serial out, all four SPI modes.
// Optional SPI_TX_BURST_EN lets back-to-back words share one chip-select assertion.
module spi_tx_master #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter bit CPOL    = 1'b0,
    parameter bit CPHA    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sclk_out,
    output logic              mosi_out,
    output logic              cs_n_out,
    output logic              busy
);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t             state;
    logic [DATA_W-1:0]  shreg;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               div_last;
    logic               leading;
    logic               accept;

    assign div_last = (div_cnt == DIV_LAST);
    // sclk still at idle level means the coming toggle is a leading edge
    assign leading  = (sclk_out == CPOL);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

`ifdef SPI_TX_BURST_EN
    assign in_ready = !rst && ((state == IDLE) || (state == HOLD && div_last));
`else
    assign in_ready = !rst && (state == IDLE);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sclk_out <= CPOL;
            mosi_out <= 1'b0;
            cs_n_out <= 1'b1;
        end else begin
            div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    if (accept) begin
                        state    <= SETUP;
                        shreg    <= in_data;
                        bit_cnt  <= '0;
                        cs_n_out <= 1'b0;
                        sclk_out <= CPOL;
                        mosi_out <= CPHA ? 1'b0 : in_data[DATA_W-1];
                    end
                end
                SETUP: if (div_last) state <= SHIFT;
                SHIFT: if (div_last) begin
                    sclk_out <= ~sclk_out;
                    if (leading) begin
                        if (CPHA) begin
                            mosi_out <= shreg[DATA_W-1];
                            shreg    <= {shreg[DATA_W-2:0], 1'b0};
                        end
                    end else if (bit_cnt == BIT_LAST) begin
                        state   <= HOLD;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (!CPHA) begin
                            mosi_out <= shreg[DATA_W-2];
                            shreg    <= {shreg[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                HOLD: if (div_last) begin
`ifdef SPI_TX_BURST_EN
                    if (accept) begin
                        // chained word: cs_n stays low, GAP skipped
                        state    <= SETUP;
                        shreg    <= in_data;
                        bit_cnt  <= '0;
                        sclk_out <= CPOL;
                        mosi_out <= CPHA ? 1'b0 : in_data[DATA_W-1];
                    end else begin
                        state    <= GAP;
                        cs_n_out <= 1'b1;
                        mosi_out <= 1'b0;
                    end
`else
                    state    <= GAP;
                    cs_n_out <= 1'b1;
                    mosi_out <= 1'b0;
`endif
                end
                GAP: if (div_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_tx_master.sv
// Directed bench for spi_tx_master: five instances cover modes 0..3 and a DATA_W=16/CLK_DIV=1 build.
// A negedge-sampled receiver model decodes each instance's SPI lines independently of the RTL.
module tb_spi_tx_master;
    localparam int N = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  vin;
    logic [31:0]   din [N];
    logic [N-1:0]  rdy, sclk, mosi, csn, bsy;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    function automatic bit cpol_of(int i); return (i == 2) || (i == 3); endfunction
    function automatic bit cpha_of(int i); return (i == 1) || (i == 3); endfunction
    function automatic int dw_of(int i);   return (i == 4) ? 16 : 8;    endfunction

    spi_tx_master #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0)) u0 (
        .clk(clk), .rst(rst), .in_data(din[0][7:0]), .in_valid(vin[0]), .in_ready(rdy[0]),
        .sclk_out(sclk[0]), .mosi_out(mosi[0]), .cs_n_out(csn[0]), .busy(bsy[0]));
    spi_tx_master #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b1)) u1 (
        .clk(clk), .rst(rst), .in_data(din[1][7:0]), .in_valid(vin[1]), .in_ready(rdy[1]),
        .sclk_out(sclk[1]), .mosi_out(mosi[1]), .cs_n_out(csn[1]), .busy(bsy[1]));
    spi_tx_master #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b0)) u2 (
        .clk(clk), .rst(rst), .in_data(din[2][7:0]), .in_valid(vin[2]), .in_ready(rdy[2]),
        .sclk_out(sclk[2]), .mosi_out(mosi[2]), .cs_n_out(csn[2]), .busy(bsy[2]));
    spi_tx_master #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1)) u3 (
        .clk(clk), .rst(rst), .in_data(din[3][7:0]), .in_valid(vin[3]), .in_ready(rdy[3]),
        .sclk_out(sclk[3]), .mosi_out(mosi[3]), .cs_n_out(csn[3]), .busy(bsy[3]));
    spi_tx_master #(.DATA_W(16), .CLK_DIV(1), .CPOL(1'b0), .CPHA(1'b0)) u4 (
        .clk(clk), .rst(rst), .in_data(din[4][15:0]), .in_valid(vin[4]), .in_ready(rdy[4]),
        .sclk_out(sclk[4]), .mosi_out(mosi[4]), .cs_n_out(csn[4]), .busy(bsy[4]));

    // receiver model state, cleared on each cs_n falling edge
    int          bits  [N] = '{default: 0};
    int          nw    [N] = '{default: 0};
    int          lowc  [N] = '{default: 0};
    int          rises [N] = '{default: 0};
    int          nfall [N] = '{default: 0};
    int          hirun [N] = '{default: 0};
    int          gap   [N] = '{default: 0};
    logic [31:0] sh    [N] = '{default: '0};
    logic [31:0] w     [N][4];
    logic        ps    [N] = '{default: 1'b0};
    logic        pc    [N] = '{default: 1'b1};

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (pc[i] && !csn[i]) begin
                bits[i] = 0; nw[i] = 0; lowc[i] = 0; rises[i] = 0; sh[i] = '0;
                nfall[i]++;
                gap[i] = hirun[i];
            end
            if (csn[i]) hirun[i]++;
            else begin hirun[i] = 0; lowc[i]++; end
            if (!csn[i] && (sclk[i] != ps[i])) begin
                if (sclk[i]) rises[i]++;
                // sample edge: leading for CPHA=0, trailing for CPHA=1
                if ((sclk[i] != cpol_of(i)) == !cpha_of(i)) begin
                    sh[i] = {sh[i][30:0], mosi[i]};
                    bits[i]++;
                    if (bits[i] == dw_of(i)) begin
                        w[i][nw[i] & 3] = sh[i];
                        nw[i]++;
                        bits[i] = 0;
                        sh[i] = '0;
                    end
                end
            end
            ps[i] = sclk[i];
            pc[i] = csn[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // present a word, return one cycle after the accepting posedge with in_valid dropped
    task automatic send(input int i, input logic [31:0] d);
        int t = 0;
        @(negedge clk);
        din[i] = d;
        vin[i] = 1'b1;
        while (!rdy[i] && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 vin[i] = 1'b0;
    endtask

    // posedges until the instance is back in IDLE
    task automatic wait_idle(input int i, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!(rdy[i] && !bsy[i]) && n < 500);
        if (n >= 500) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n, n2, f0, t;
        rst = 1'b1;
        vin = '0;
        for (int i = 0; i < N; i++) din[i] = '0;
        #3;
        chk("rst_sclk0", {31'd0, sclk[0]}, 32'd0);
        chk("rst_sclk2", {31'd0, sclk[2]}, 32'd1);
        chk("rst_mosi",  {31'd0, mosi[0]}, 32'd0);
        chk("rst_csn",   {31'd0, csn[0]},  32'd1);
        chk("rst_rdy",   {31'd0, rdy[0]},  32'd0);
        chk("rst_busy",  {31'd0, bsy[0]},  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_rdy", {31'd0, rdy[0]}, 32'd1);

        // mode 0, 0xA5: cs_n low through SETUP+SHIFT+HOLD = 2*(16+2) cycles
        send(0, 32'hA5);
        wait_idle(0, n);
        chk("m0_frame_len", n, 32'd38);
        chk("m0_word",      w[0][0], 32'hA5);
        chk("m0_nwords",    nw[0], 32'd1);
        chk("m0_cs_low",    lowc[0], 32'd36);
        chk("m0_rises",     rises[0], 32'd8);
        chk("m0_csn_end",   {31'd0, csn[0]}, 32'd1);

        // modes 1..3 with 0x3C
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("m%0d_sclk_idle", i), {31'd0, sclk[i]}, {31'd0, cpol_of(i)});
            send(i, 32'h3C);
            wait_idle(i, n);
            chk($sformatf("m%0d_frame_len", i), n, 32'd38);
            chk($sformatf("m%0d_word", i), w[i][0], 32'h3C);
            chk($sformatf("m%0d_sclk_end", i), {31'd0, sclk[i]}, {31'd0, cpol_of(i)});
        end

        // reset in the 5th SHIFT half-period (cycles 10..11 after accept)
        send(0, 32'hFF);
        repeat (10) @(posedge clk);
        #1;
        chk("ab_pre_csn",  {31'd0, csn[0]},  32'd0);
        chk("ab_pre_mosi", {31'd0, mosi[0]}, 32'd1);
        chk("ab_pre_busy", {31'd0, bsy[0]},  32'd1);
        rst = 1'b1;
        #1;
        chk("ab_csn",  {31'd0, csn[0]},  32'd1);
        chk("ab_sclk", {31'd0, sclk[0]}, 32'd0);
        chk("ab_mosi", {31'd0, mosi[0]}, 32'd0);
        chk("ab_rdy",  {31'd0, rdy[0]},  32'd0);
        chk("ab_busy", {31'd0, bsy[0]},  32'd0);
        chk("ab_sclk2", {31'd0, sclk[2]}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ab_rdy_after", {31'd0, rdy[0]}, 32'd1);

        // in_valid held across two words
        f0 = nfall[0];
        t = 0;
        @(negedge clk);
        din[0] = 32'h11;
        vin[0] = 1'b1;
        while (!rdy[0] && t < 200) begin @(negedge clk); t++; end
        @(posedge clk);
        #1 din[0] = 32'h22;
`ifdef SPI_TX_BURST_EN
        // ready comes back in the last HOLD cycle: 2*(16+2)-1 posedges after accept
        n = 0;
        do begin @(posedge clk); n++; #1; end while (!rdy[0] && n < 500);
        chk("bu_rdy_hold", n, 32'd35);
        chk("bu_busy_hold", {31'd0, bsy[0]}, 32'd1);
        @(posedge clk);
        #1 vin[0] = 1'b0;
        chk("bu_csn_held", {31'd0, csn[0]}, 32'd0);
        wait_idle(0, n2);
        chk("bu_frame2_len", n2, 32'd38);
        chk("bu_nwords", nw[0], 32'd2);
        chk("bu_word0",  w[0][0], 32'h11);
        chk("bu_word1",  w[0][1], 32'h22);
        chk("bu_one_cs", nfall[0] - f0, 32'd1);
        chk("bu_csn_end", {31'd0, csn[0]}, 32'd1);
`else
        wait_idle(0, n);
        chk("nb_frame1_len", n, 32'd38);
        chk("nb_word0", w[0][0], 32'h11);
        n2 = 0;
        while (!bsy[0] && n2 < 10) begin @(posedge clk); #1; n2++; end
        vin[0] = 1'b0;
        chk("nb_accept2", n2, 32'd1);
        wait_idle(0, n2);
        chk("nb_frame2_len", n2, 32'd38);
        chk("nb_word1", w[0][0], 32'h22);
        chk("nb_two_cs", nfall[0] - f0, 32'd2);
        // cs_n high for GAP plus the IDLE cycle in which the next word is accepted
        chk("nb_gap", gap[0], 32'd3);
`endif

        // DATA_W=16, CLK_DIV=1: sclk toggles every clk through SHIFT
        send(4, 32'h8001);
        wait_idle(4, n);
        chk("w16_frame_len", n, 32'd35);
        chk("w16_word",   w[4][0], 32'h8001);
        chk("w16_rises",  rises[4], 32'd16);
        chk("w16_cs_low", lowc[4], 32'd34);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
